// File: rtl/ptvm_pkg.sv
// Shared types and constants for the vending-machine change dispenser:
// dispenser state encoding, coin values and the coin-select encoding.
package ptvm_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SELECT,
    ST_DRIVE,
    ST_WAIT_SENSE,
    ST_FINISH,
    ST_FAULT
  } disp_state_t;

  localparam int NICKEL_UNITS = 1;
  localparam int DIME_UNITS   = 2;

  typedef enum logic [1:0] {
    SEL_NONE,
    SEL_NICKEL,
    SEL_DIME
  } coin_sel_t;

  // Timer width able to hold the larger of the pulse and timeout loads.
  function automatic int tmr_width(input int a, input int b);
    int m;
    m = (a > b) ? a : b;
    return $clog2(m) + 1;
  endfunction

endpackage

// File: rtl/ptvm_chg_timer.sv
// Loadable down-counter shared by the hopper drive pulse and the coin-sense wait.
// expired flags the final cycle of a loaded interval (count == 1).
module ptvm_chg_timer #(
  parameter int W = 7
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         expired
);

  logic [W-1:0] r_count;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_count <= '0;
    end else if (load) begin
      r_count <= load_val;
    end else if (r_count != '0) begin
      r_count <= r_count - 1'b1;
    end
  end

  // A load of N therefore gives exactly N cycles before the owner acts on expiry.
  assign expired = (r_count == W'(1));

endmodule

// File: rtl/ptvm_change_dispenser.sv
// Change dispenser: pays a nickel-unit amount greedily as dimes then nickels,
// confirming each coin on the drop sensor. PTVM_CHG_STATS_EN adds coin counters.
module ptvm_change_dispenser
  import ptvm_pkg::*;
#(
  parameter int AMT_W       = 3,
  parameter int PULSE_CYC   = 4,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [AMT_W-1:0] req_amount,
  input  logic             nickel_empty,
  input  logic             dime_empty,
  input  logic             coin_sense,
  output logic             nickel_drive,
  output logic             dime_drive,
  output logic             busy,
  output logic             done,
  output logic             error,
  output logic [AMT_W-1:0] remaining
`ifdef PTVM_CHG_STATS_EN
  ,
  output logic [7:0]       nickel_count,
  output logic [7:0]       dime_count
`endif
);

  localparam int TMR_W = tmr_width(PULSE_CYC, TIMEOUT_CYC);

  disp_state_t      r_state;
  coin_sel_t        r_sel;
  logic [AMT_W-1:0] r_remaining;
  logic             r_nickel_drive;
  logic             r_dime_drive;
  logic             r_busy;
  logic             r_req_ready;
  logic             r_done;
  logic             r_error;

  coin_sel_t        w_pick;
  logic [AMT_W-1:0] w_units;
  logic             w_tmr_load;
  logic [TMR_W-1:0] w_tmr_val;
  logic             w_tmr_expired;
  logic             w_coin_ok;

  // Greedy choice; hopper-empty levels only matter while in SELECT.
  always_comb begin
    w_pick = SEL_NONE;
    if (r_remaining >= AMT_W'(DIME_UNITS) && !dime_empty) begin
      w_pick = SEL_DIME;
    end else if (r_remaining != '0 && !nickel_empty) begin
      w_pick = SEL_NICKEL;
    end
  end

  assign w_units    = (r_sel == SEL_DIME) ? AMT_W'(DIME_UNITS) : AMT_W'(NICKEL_UNITS);
  assign w_coin_ok  = (r_state == ST_WAIT_SENSE) && coin_sense;
  assign w_tmr_load = ((r_state == ST_SELECT) && (r_remaining != '0) && (w_pick != SEL_NONE))
                   || ((r_state == ST_DRIVE) && w_tmr_expired);
  assign w_tmr_val  = (r_state == ST_SELECT) ? TMR_W'(PULSE_CYC) : TMR_W'(TIMEOUT_CYC);

  ptvm_chg_timer #(
    .W (TMR_W)
  ) u_timer (
    .clock    (clock),
    .reset    (reset),
    .load     (w_tmr_load),
    .load_val (w_tmr_val),
    .expired  (w_tmr_expired)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state        <= ST_IDLE;
      r_sel          <= SEL_NONE;
      r_remaining    <= '0;
      r_nickel_drive <= 1'b0;
      r_dime_drive   <= 1'b0;
      r_busy         <= 1'b0;
      r_req_ready    <= 1'b1;
      r_done         <= 1'b0;
      r_error        <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (req_valid && r_req_ready) begin
            r_remaining <= req_amount;
            r_error     <= 1'b0;
            r_req_ready <= 1'b0;
            r_busy      <= 1'b1;
            r_state     <= ST_SELECT;
          end
        end
        ST_SELECT: begin
          if (r_remaining == '0) begin
            r_done  <= 1'b1;
            r_state <= ST_FINISH;
          end else begin
            r_sel <= w_pick;
            case (w_pick)
              SEL_DIME: begin
                r_dime_drive <= 1'b1;
                r_state      <= ST_DRIVE;
              end
              SEL_NICKEL: begin
                r_nickel_drive <= 1'b1;
                r_state        <= ST_DRIVE;
              end
              default: begin
                r_error <= 1'b1;
                r_done  <= 1'b1;
                r_state <= ST_FAULT;
              end
            endcase
          end
        end
        ST_DRIVE: begin
          if (w_tmr_expired) begin
            r_nickel_drive <= 1'b0;
            r_dime_drive   <= 1'b0;
            r_state        <= ST_WAIT_SENSE;
          end
        end
        ST_WAIT_SENSE: begin
          // A sense landing on the expiry cycle still counts as delivered.
          if (coin_sense) begin
            r_remaining <= r_remaining - w_units;
            r_state     <= ST_SELECT;
          end else if (w_tmr_expired) begin
            r_error <= 1'b1;
            r_done  <= 1'b1;
            r_state <= ST_FAULT;
          end
        end
        ST_FINISH, ST_FAULT: begin
          r_busy      <= 1'b0;
          r_req_ready <= 1'b1;
          r_state     <= ST_IDLE;
        end
        default: begin
          r_nickel_drive <= 1'b0;
          r_dime_drive   <= 1'b0;
          r_busy         <= 1'b0;
          r_req_ready    <= 1'b1;
          r_state        <= ST_IDLE;
        end
      endcase
    end
  end

  assign req_ready    = r_req_ready;
  assign nickel_drive = r_nickel_drive;
  assign dime_drive   = r_dime_drive;
  assign busy         = r_busy;
  assign done         = r_done;
  assign error        = r_error;
  assign remaining    = r_remaining;

`ifdef PTVM_CHG_STATS_EN
  logic [7:0] r_nickel_count;
  logic [7:0] r_dime_count;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_nickel_count <= '0;
      r_dime_count   <= '0;
    end else if (w_coin_ok) begin
      if (r_sel == SEL_DIME) begin
        if (r_dime_count != 8'hFF) r_dime_count <= r_dime_count + 1'b1;
      end else begin
        if (r_nickel_count != 8'hFF) r_nickel_count <= r_nickel_count + 1'b1;
      end
    end
  end

  assign nickel_count = r_nickel_count;
  assign dime_count   = r_dime_count;
`endif

endmodule

// File: tb/tb_ptvm_change_dispenser.sv
// Directed bench for ptvm_change_dispenser: hand-computed latencies, pulse
// widths and status per request; a responder returns coin_sense after each pulse.
module tb_ptvm_change_dispenser;

  logic       clock;
  logic       reset;
  logic       req_valid;
  logic       req_ready;
  logic [2:0] req_amount;
  logic       nickel_empty;
  logic       dime_empty;
  logic       coin_sense;
  logic       nickel_drive;
  logic       dime_drive;
  logic       busy;
  logic       done;
  logic       error;
  logic [2:0] remaining;
`ifdef PTVM_CHG_STATS_EN
  logic [7:0] nickel_count;
  logic [7:0] dime_count;
`endif

  int n_cmp;
  int n_mis;

  // Monitor state, written only by the monitor process.
  int  dime_cyc;
  int  nick_cyc;
  int  dime_pulses;
  int  nick_pulses;
  int  both_cnt;
  logic prev_dime;
  logic prev_nick;

  // Responder control, written only by the main process.
  logic sense_en;

  ptvm_change_dispenser dut (
    .clock        (clock),
    .reset        (reset),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_amount   (req_amount),
    .nickel_empty (nickel_empty),
    .dime_empty   (dime_empty),
    .coin_sense   (coin_sense),
    .nickel_drive (nickel_drive),
    .dime_drive   (dime_drive),
    .busy         (busy),
    .done         (done),
    .error        (error),
    .remaining    (remaining)
`ifdef PTVM_CHG_STATS_EN
    ,
    .nickel_count (nickel_count),
    .dime_count   (dime_count)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  initial begin
    dime_cyc = 0; nick_cyc = 0; dime_pulses = 0; nick_pulses = 0; both_cnt = 0;
    prev_dime = 1'b0; prev_nick = 1'b0;
    forever begin
      @(negedge clock);
      if (dime_drive) dime_cyc++;
      if (nickel_drive) nick_cyc++;
      if (dime_drive && !prev_dime) dime_pulses++;
      if (nickel_drive && !prev_nick) nick_pulses++;
      if (dime_drive && nickel_drive) both_cnt++;
      prev_dime = dime_drive;
      prev_nick = nickel_drive;
    end
  end

  // Returns one coin_sense pulse, sampled on the 2nd wait cycle after a drive ends.
  initial begin
    logic seen;
    seen = 1'b0;
    coin_sense = 1'b0;
    forever begin
      @(negedge clock);
      if (dime_drive || nickel_drive) begin
        seen = 1'b1;
      end else if (seen) begin
        seen = 1'b0;
        if (sense_en) begin
          @(negedge clock);
          coin_sense = 1'b1;
          @(negedge clock);
          coin_sense = 1'b0;
        end
      end
    end
  end

  // Issues one request and returns negedges from handshake to done.
  task automatic do_req(input logic [2:0] amt, output int lat);
    int waitc;
    lat = 0;
    waitc = 0;
    @(negedge clock);
    req_valid  = 1'b1;
    req_amount = amt;
    while (!req_ready && waitc < 200) begin
      @(negedge clock);
      waitc++;
    end
    chk("ready_seen", {31'd0, req_ready}, 32'd1);
    do begin
      @(negedge clock);
      req_valid = 1'b0;
      lat++;
    end while (!done && lat < 200);
    chk("done_seen", {31'd0, done}, 32'd1);
    $display("req amt=%0d lat=%0d err=%0d rem=%0d", amt, lat, error, remaining);
  endtask

  initial begin
    int lat;
    int d0, n0, dp0, np0;
    int waitc;
    n_cmp = 0;
    n_mis = 0;
    reset = 1'b1;
    req_valid = 1'b0;
    req_amount = '0;
    nickel_empty = 1'b0;
    dime_empty = 1'b0;
    sense_en = 1'b1;
    repeat (3) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    chk("rst_ready", {31'd0, req_ready}, 32'd1);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_error", {31'd0, error}, 32'd0);
    chk("rst_rem", {29'd0, remaining}, 32'd0);
    chk("rst_drv", {30'd0, dime_drive, nickel_drive}, 32'd0);

    // 3 units, both full: dime then nickel, 7 cycles per coin + SELECT + FINISH.
    d0 = dime_cyc; n0 = nick_cyc; dp0 = dime_pulses; np0 = nick_pulses;
    do_req(3'd3, lat);
    chk("a3_lat", lat, 32'd16);
    chk("a3_dcyc", dime_cyc - d0, 32'd4);
    chk("a3_ncyc", nick_cyc - n0, 32'd4);
    chk("a3_dp", dime_pulses - dp0, 32'd1);
    chk("a3_np", nick_pulses - np0, 32'd1);
    chk("a3_err", {31'd0, error}, 32'd0);
    chk("a3_rem", {29'd0, remaining}, 32'd0);
    chk("a3_busy", {31'd0, busy}, 32'd1);
    @(negedge clock);
    chk("a3_done_1cyc", {31'd0, done}, 32'd0);
    chk("a3_idle_ready", {31'd0, req_ready}, 32'd1);
    chk("a3_idle_busy", {31'd0, busy}, 32'd0);

    // 4 units with dimes empty: four nickels.
    dime_empty = 1'b1;
    d0 = dime_cyc; n0 = nick_cyc; np0 = nick_pulses;
    do_req(3'd4, lat);
    chk("a4_lat", lat, 32'd30);
    chk("a4_dcyc", dime_cyc - d0, 32'd0);
    chk("a4_ncyc", nick_cyc - n0, 32'd16);
    chk("a4_np", nick_pulses - np0, 32'd4);
    chk("a4_err", {31'd0, error}, 32'd0);
    chk("a4_rem", {29'd0, remaining}, 32'd0);

    // 2 units, both empty: immediate shortfall fault.
    nickel_empty = 1'b1;
    d0 = dime_cyc; n0 = nick_cyc;
    do_req(3'd2, lat);
    chk("e2_lat", lat, 32'd2);
    chk("e2_err", {31'd0, error}, 32'd1);
    chk("e2_rem", {29'd0, remaining}, 32'd2);
    chk("e2_drv", (dime_cyc - d0) + (nick_cyc - n0), 32'd0);
    @(negedge clock);
    chk("e2_err_sticky", {31'd0, error}, 32'd1);
    chk("e2_done_1cyc", {31'd0, done}, 32'd0);
    chk("e2_rem_hold", {29'd0, remaining}, 32'd2);
    nickel_empty = 1'b0;
    dime_empty = 1'b0;

    // 1 unit, no sense: 4 drive + 64 wait cycles then fault.
    sense_en = 1'b0;
    n0 = nick_cyc;
    do_req(3'd1, lat);
    chk("to_lat", lat, 32'd70);
    chk("to_ncyc", nick_cyc - n0, 32'd4);
    chk("to_err", {31'd0, error}, 32'd1);
    chk("to_rem", {29'd0, remaining}, 32'd1);
    sense_en = 1'b1;
    do_req(3'd0, lat);
    chk("z_lat", lat, 32'd2);
    chk("z_err", {31'd0, error}, 32'd0);
    chk("z_rem", {29'd0, remaining}, 32'd0);

    // Reset during the 2nd cycle of a dime pulse.
    @(negedge clock);
    req_valid  = 1'b1;
    req_amount = 3'd2;
    waitc = 0;
    while (!dime_drive && waitc < 20) begin
      @(negedge clock);
      req_valid = 1'b0;
      waitc++;
    end
    chk("rr_dime_on", {31'd0, dime_drive}, 32'd1);
    @(negedge clock);
    chk("rr_dime_2nd", {31'd0, dime_drive}, 32'd1);
    reset = 1'b1;
    @(negedge clock);
    chk("rr_dime_off", {31'd0, dime_drive}, 32'd0);
    reset = 1'b0;
    chk("rr_ready", {31'd0, req_ready}, 32'd1);
    chk("rr_busy", {31'd0, busy}, 32'd0);
    chk("rr_rem", {29'd0, remaining}, 32'd0);
    $display("reset mid-dime: drive=%0d ready=%0d busy=%0d rem=%0d", dime_drive, req_ready, busy, remaining);

`ifdef PTVM_CHG_STATS_EN
    for (int i = 0; i < 300; i++) begin
      do_req(3'd1, lat);
    end
    chk("st_nick", {24'd0, nickel_count}, 32'd255);
    chk("st_dime", {24'd0, dime_count}, 32'd0);
`endif

    chk("never_both", both_cnt, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
